// File: rtl/imem_boot_ctrl_if.sv
// Loader stream, fetch port and status bundle for imem_boot_ctrl.
// Loader handshake: a byte moves on every rising edge where ld_valid && ld_ready; ld_data/ld_last
// are only meaningful while ld_valid is high, and ld_ready never depends on ld_valid.
interface imem_boot_ctrl_if #(
   parameter int AW = 6
);
   logic          ld_start;
   logic          ld_valid;
   logic [7:0]    ld_data;
   logic          ld_last;
   logic          ld_ready;
   logic          fetch_req;
   logic [31:0]   fetch_pc;
   logic          fetch_valid;
   logic [31:0]   fetch_instr;
   logic          stall;
   logic [AW:0]   load_count;
   logic [1:0]    err_code;

   modport master (
      output ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_pc,
      input  ld_ready, fetch_valid, fetch_instr, stall, load_count, err_code
   );

   modport slave (
      input  ld_start, ld_valid, ld_data, ld_last, fetch_req, fetch_pc,
      output ld_ready, fetch_valid, fetch_instr, stall, load_count, err_code
   );
endinterface

// File: rtl/imem_boot_ctrl.sv
// Boot loader and registered 32-bit big-endian fetch port for a DEPTH-byte instruction store.
// The pipeline is stalled until a complete, word-aligned program has been loaded.
module imem_boot_ctrl #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic               clk,
   input  logic               reset,
   imem_boot_ctrl_if.slave    bus,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      RUN   = 2'd2,
      FAULT = 2'd3
   } state_t;

   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   state_t        state;
   state_t        state_n;
   logic [AW-1:0] ptr;
   logic [AW:0]   load_count;
   logic [AW:0]   count_inc;
   logic [1:0]    err_code;
   logic          fetch_valid;
   logic [31:0]   fetch_instr;
   logic [7:0]    mem [DEPTH];

   logic          accept;
   logic          fetch_take;
   logic          misaligned;
   logic          out_of_range;
   logic [31:0]   rd_word;

   assign count_inc = load_count + (AW+1)'(1);

   always_comb begin
      state_n      = state;
      accept       = (state == LOAD) && bus.ld_valid && !bus.ld_start;
      fetch_take   = (state == RUN) && bus.fetch_req;
      misaligned   = (bus.fetch_pc[1:0] != 2'b00);
      // 33-bit compare so a PC near 2^32 cannot wrap back into the loaded image.
      out_of_range = ({1'b0, bus.fetch_pc} + 33'd4) > {{(32-AW){1'b0}}, load_count};
      rd_word      = {mem[{bus.fetch_pc[AW-1:2], 2'd0}], mem[{bus.fetch_pc[AW-1:2], 2'd1}],
                      mem[{bus.fetch_pc[AW-1:2], 2'd2}], mem[{bus.fetch_pc[AW-1:2], 2'd3}]};
      if (bus.ld_start) begin
         state_n = LOAD;
      end else if (accept) begin
         if (bus.ld_last)
            state_n = (count_inc[1:0] == 2'b00) ? RUN : FAULT;
         else if (ptr == LAST_PTR)
            state_n = FAULT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         ptr         <= '0;
         load_count  <= '0;
         err_code    <= 2'd0;
         fetch_valid <= 1'b0;
         fetch_instr <= 32'd0;
      end else begin
         state       <= state_n;
         fetch_valid <= fetch_take;
         if (fetch_take)
            fetch_instr <= (misaligned || out_of_range) ? 32'd0 : rd_word;
         if (bus.ld_start) begin
            ptr        <= '0;
            load_count <= '0;
            err_code   <= 2'd0;
         end else begin
            if (accept) begin
               ptr        <= ptr + AW'(1);
               load_count <= count_inc;
               if (state_n == FAULT)
                  err_code <= 2'd3;
            end
            if (fetch_take) begin
               if (misaligned)
                  err_code <= 2'd1;
               else if (out_of_range)
                  err_code <= 2'd2;
            end
         end
      end
   end

   // Store contents survive reset; they are simply unusable until a new load completes.
   always_ff @(posedge clk) begin
      if (accept)
         mem[ptr] <= bus.ld_data;
   end

   assign bus.ld_ready    = (state == LOAD);
   assign bus.stall       = (state != RUN);
   assign bus.fetch_valid = fetch_valid;
   assign bus.fetch_instr = fetch_instr;
   assign bus.load_count  = load_count;
   assign bus.err_code    = err_code;
   assign dbg_state       = state;

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot/load controller and fetch port for the byte-addressed, big-endian instruction memory that feeds the IF stage. It owns a DEPTH-byte instruction store, fills it from a byte-wide valid/ready loader stream, and holds the pipeline stalled until a complete, word-aligned program is present. It then serves registered 32-bit fetches to the pipeline, flagging misaligned and out-of-range PCs.

## Interface
- DEPTH, 64: instruction store size in bytes; multiple of 4, power of 2, ≥ 8.
- AW, 6: log2(DEPTH).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ld_start  in  1  one-cycle request to (re)start a program load.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte; stream order is address 0 upward, MSB-first within each word.
- ld_last  in  1  qualifies the final byte of the program; meaningful only with ld_valid.
- ld_ready  out  1  block accepts a byte this cycle.
- fetch_req  in  1  pipeline fetch request.
- fetch_pc  in  32  byte address of the instruction.
- fetch_valid  out  1  fetch_instr valid (one-cycle pulse).
- fetch_instr  out  32  {mem[pc], mem[pc+1], mem[pc+2], mem[pc+3]}, or 0 on error.
- stall  out  1  high whenever the state is not RUN; the pipeline freezes PC.
- load_count  out  AW+1  number of bytes loaded in the current or last load.
- err_code  out  2  sticky: 0 none, 1 misaligned fetch, 2 out-of-range fetch, 3 load fault.

## Operation
- States: IDLE, LOAD, RUN, FAULT. Reset forces IDLE.
- On reset: stall=1, ld_ready=0, fetch_valid=0, fetch_instr=0, load_count=0, err_code=0. Store contents are not cleared; they are retained but treated as invalid.
- IDLE: ld_start -> LOAD. All other inputs are ignored.
- LOAD entry, from any state via ld_start: write pointer=0, load_count=0, err_code=0. ld_ready=1 for as long as the state is LOAD.
- Byte acceptance: ld_valid && ld_ready. On acceptance, mem[ptr] ← ld_data, ptr and load_count increment.
- Accepted byte with ld_last:
  - new count % 4 == 0 -> RUN.
  - otherwise -> FAULT, err_code=3.
- Accepted byte that fills slot DEPTH-1 without ld_last -> FAULT, err_code=3. Ready never wraps.
- ld_start while in LOAD restarts the load at pointer 0. It takes priority over a byte presented in the same cycle; that byte is not written.
- RUN: a fetch_req sampled at an edge while the state is RUN produces a response at the next edge:
  - fetch_pc[1:0] != 0 -> fetch_instr=0, err_code=1.
  - else if fetch_pc + 4 > load_count (33-bit compare, no wrap) -> fetch_instr=0, err_code=2.
  - else fetch_instr = 4 bytes, big-endian, and err_code is unchanged.
  - fetch_valid=1 in every one of these cases.
- Misaligned takes precedence over out-of-range.
- err_code values 1 and 2 are sticky until ld_start or reset; a later error overwrites the earlier one.
- RUN + ld_start -> LOAD (reprogram). A fetch sampled in that same cycle still completes.
- FAULT: stall=1, ld_ready=0, fetches are ignored. Exit only via ld_start or reset.
- fetch_req outside RUN is ignored: no fetch_valid, err_code unchanged.

## Timing
- ld_start at edge N -> ld_ready=1 from N+1.
- Byte written at the edge where it is accepted; load_count reflects it after that edge.
- Final byte accepted at edge N -> state RUN and stall=0 from N+1. A fetch_req sampled at N is ignored; the first usable fetch is sampled at N+1.
- Fetch latency is 1 cycle: request sampled at edge N, fetch_valid/fetch_instr held N..N+1, with a back-to-back request every cycle supported. fetch_instr holds its last value when fetch_valid=0.
- Reset asserted mid-load or mid-fetch: outputs take their reset values immediately (asynchronous), any pending fetch response is dropped, and the partial load is discarded.

## Test plan
- Load 32 bytes A0 41 00 0C A0 83 00 12 … 3C 06 00 80 with ld_last on byte 31 -> stall falls the cycle after, load_count=32. Fetch pc=0 -> A041000C and pc=28 -> 3C060080, each 1 cycle later, err_code=0.
- After that load, fetch pc=6 -> fetch_valid=1, instr=0, err_code=1. Then fetch pc=32 -> instr=0, err_code=2. Then fetch pc=0xFFFFFFFC -> err_code=2, with no wrap to address 0.
- Load 6 bytes with ld_last on byte 5 -> FAULT, err_code=3, stall=1, ld_ready=0. Subsequent fetch_req -> no fetch_valid.
- Load 64 bytes without ld_last -> FAULT after byte 63, err_code=3. Then ld_start plus 8 valid bytes -> RUN, load_count=8, err_code=0.
- ld_start asserted mid-load, coincident with a valid byte -> that byte is not written, pointer restarts at 0, and the first byte after restart lands at address 0, verified by fetch pc=0.
- Reset asserted during RUN with fetch_req high -> fetch_valid=0 and stall=1 immediately, state IDLE, and ld_ready stays 0 until ld_start.
